// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 codes,
// FSM states, access sizes and lane helpers.
package mem_pkg;

    localparam int STRB_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Unknown funct3 codes fall through to a full-word access.
    function automatic size_t op_size(input logic [2:0] f3,
                                      input logic store);
        size_t s;
        s = SZ_W;
        if (store) begin
            if (f3 == F3_SB) s = SZ_B;
            else if (f3 == F3_SH) s = SZ_H;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU) s = SZ_B;
            else if (f3 == F3_LH || f3 == F3_LHU) s = SZ_H;
        end
        return s;
    endfunction

    function automatic logic [STRB_W-1:0] store_strb(input size_t s,
                                                     input logic [1:0] off);
        logic [STRB_W-1:0] st;
        st = 4'b1111;
        if (s == SZ_B) st = 4'b0001 << off;
        else if (s == SZ_H) st = 4'b0011 << {off[1], 1'b0};
        return st;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Load lane extraction and sign/zero extension for the
// memory-access stage.
module load_align
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] data
);

    size_t      sz;
    logic       sgn;
    logic [7:0] b;
    logic [15:0] h;

    assign sz  = op_size(funct3, 1'b0);
    assign sgn = ~funct3[2];
    assign b   = rdata[{off, 3'b000} +: 8];
    assign h   = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        unique case (sz)
            SZ_B:    data = {{(WIDTH-8){sgn & b[7]}}, b};
            SZ_H:    data = {{(WIDTH-16){sgn & h[15]}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: ALU pass-through, load/store FSM.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module memory_access
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [WIDTH-1:0]  ex_result,
    input  logic [WIDTH-1:0]  ex_store_data,
    input  logic [4:0]        ex_rd_sel,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_load,
    input  logic              ex_store,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WIDTH-1:0]  dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [WIDTH-1:0]  dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic [4:0]        wb_rd_sel,
    output logic [WIDTH-1:0]  wb_rd,
    output logic              halt
);

    state_t     state, state_n;
    logic       xfer, mem_op, go_mem, bad;
    size_t      sz;
    logic [4:0] pend_rd;
    logic [2:0] pend_f3;
    logic [1:0] pend_off;
    logic       pend_load;
    logic [WIDTH-1:0] ld_data;

    assign ex_ready = (state == IDLE);
    assign halt     = (state == WAIT);
    assign xfer     = ex_valid & ex_ready;
    assign mem_op   = ex_load | ex_store;
    assign sz       = op_size(ex_funct3, ex_store);

`ifdef MEM_MISALIGN_TRAP_EN
    assign bad = ((sz == SZ_H) & ex_result[0])
               | ((sz == SZ_W) & (ex_result[1:0] != 2'b00));
`else
    assign bad = 1'b0;
`endif

    assign go_mem = xfer & mem_op & ~bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go_mem) state_n = WAIT;
            WAIT: if (dmem_ack) state_n = IDLE;
        endcase
    end

    load_align #(.WIDTH(WIDTH)) u_align (
        .funct3 (pend_f3),
        .off    (pend_off),
        .rdata  (dmem_rdata),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            wb_rd_sel  <= '0;
            wb_rd      <= '0;
            pend_rd    <= '0;
            pend_f3    <= '0;
            pend_off   <= '0;
            pend_load  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            wb_rd_sel <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign  <= xfer & mem_op & bad;
`endif
            if (xfer && !mem_op) begin
                wb_rd     <= ex_result;
                wb_rd_sel <= ex_rd_sel;
            end else if (go_mem) begin
                dmem_req  <= 1'b1;
                dmem_we   <= ex_store;
                dmem_addr <= {ex_result[WIDTH-1:2], 2'b00};
                dmem_wstrb <= ex_store ? store_strb(sz, ex_result[1:0])
                                       : '0;
                unique case (sz)
                    SZ_B:    dmem_wdata <= WIDTH'({4{ex_store_data[7:0]}});
                    SZ_H:    dmem_wdata <= WIDTH'({2{ex_store_data[15:0]}});
                    default: dmem_wdata <= ex_store_data;
                endcase
                pend_rd   <= ex_rd_sel;
                pend_f3   <= ex_funct3;
                pend_off  <= ex_result[1:0];
                pend_load <= ~ex_store;
            end else if (state == WAIT && dmem_ack) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                if (pend_load) begin
                    wb_rd     <= ld_data;
                    wb_rd_sel <= pend_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus
// randomized ALU/load/store traffic against an arithmetic model.
module tb_memory_access;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_sel;
    logic [2:0]  ex_funct3;
    logic        ex_load;
    logic        ex_store;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_rd_sel;
    logic [31:0] wb_rd;
    logic        halt;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    memory_access #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd_sel     (ex_rd_sel),
        .ex_funct3     (ex_funct3),
        .ex_load       (ex_load),
        .ex_store      (ex_store),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign      (misalign),
`endif
        .wb_rd_sel     (wb_rd_sel),
        .wb_rd         (wb_rd),
        .halt          (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte offset picks the lane, sign taken from top bit.
    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input int off,
                                           input logic [31:0] w);
        logic [31:0] mask, v;
        int sh;
        bit sgn;
        case (f3)
            3'd0: begin mask = 32'hFF;   sh = 8 * off;         sgn = 1; end
            3'd1: begin mask = 32'hFFFF; sh = 16 * (off / 2);  sgn = 1; end
            3'd4: begin mask = 32'hFF;   sh = 8 * off;         sgn = 0; end
            3'd5: begin mask = 32'hFFFF; sh = 16 * (off / 2);  sgn = 0; end
            default: return w;
        endcase
        v = (w >> sh) & mask;
        if (sgn && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_strb(input logic [2:0] f3,
                                           input int off);
        case (f3)
            3'd0:    return 32'(1 << off);
            3'd1:    return 32'(3 << (off & 2));
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] d);
        case (f3)
            3'd0:    return (d & 32'hFF) * 32'h0101_0101;
            3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        ex_valid = 1; ex_load = 0; ex_store = 0;
        ex_result = res; ex_rd_sel = rd;
        ex_funct3 = 3'($urandom);
        chk("alu_ready", 32'(ex_ready), 1);
        @(posedge clk); #1;
        ex_valid = 0;
        chk("alu_sel", 32'(wb_rd_sel), 32'(rd));
        if (rd != 0) chk("alu_rd", wb_rd, res);
        chk("alu_noreq", 32'(dmem_req), 0);
        @(posedge clk); #1;
        chk("alu_sel_clr", 32'(wb_rd_sel), 0);
    endtask

    task automatic mem(input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input logic [4:0] rd,
                       input int waits);
        logic [31:0] ea;
        ea = addr & 32'hFFFF_FFFC;
        ex_valid = 1; ex_load = !st; ex_store = st;
        ex_funct3 = f3; ex_result = addr;
        ex_store_data = sdata; ex_rd_sel = rd;
        chk("mem_ready", 32'(ex_ready), 1);
        @(posedge clk); #1;
        ex_valid = 0; ex_load = 0; ex_store = 0;
        ex_result = $urandom; ex_store_data = $urandom;
        chk("req", 32'(dmem_req), 1);
        chk("we", 32'(dmem_we), 32'(st));
        chk("addr", dmem_addr, ea);
        chk("halt", 32'(halt), 1);
        chk("busy", 32'(ex_ready), 0);
        if (st) begin
            chk("strb", 32'(dmem_wstrb), m_strb(f3, int'(addr % 4)));
            chk("wdata", dmem_wdata, m_wdata(f3, sdata));
        end
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            chk("wait_req", 32'(dmem_req), 1);
            chk("wait_addr", dmem_addr, ea);
            chk("wait_halt", 32'(halt), 1);
            chk("wait_sel", 32'(wb_rd_sel), 0);
        end
        dmem_ack = 1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack = 0; dmem_rdata = $urandom;
        chk("ack_req", 32'(dmem_req), 0);
        chk("ack_halt", 32'(halt), 0);
        chk("ack_ready", 32'(ex_ready), 1);
        chk("wb_sel", 32'(wb_rd_sel), st ? 0 : 32'(rd));
        if (!st && rd != 0)
            chk("wb_rd", wb_rd, m_load(f3, int'(addr % 4), rdata));
        @(posedge clk); #1;
        chk("wb_sel_clr", 32'(wb_rd_sel), 0);
    endtask

    initial begin
        reset = 0; ex_valid = 0; ex_result = 0; ex_store_data = 0;
        ex_rd_sel = 0; ex_funct3 = 0; ex_load = 0; ex_store = 0;
        dmem_ack = 0; dmem_rdata = 0;
        #1;
        chk("rst_ready", 32'(ex_ready), 1);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_strb", 32'(dmem_wstrb), 0);
        chk("rst_sel", 32'(wb_rd_sel), 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_halt", 32'(halt), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1;

        alu(32'h1234, 5'd5);
        alu(32'hDEAD_BEEF, 5'd0);
        mem(0, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 5'd7, 3);
        mem(1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 5'd9, 0);
        mem(0, 3'b101, 32'h2, 0, 32'hBEEF_0000, 5'd3, 1);
        mem(0, 3'b011, 32'h40, 0, 32'h1357_9BDF, 5'd4, 0);
        mem(1, 3'b110, 32'h44, 32'hCAFE_F00D, 0, 5'd4, 2);
        mem(0, 3'b010, 32'h88, 0, 32'h5555_AAAA, 5'd0, 1);

        // ack while idle must not produce anything
        dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("idle_ack_sel", 32'(wb_rd_sel), 0);
        chk("idle_ack_req", 32'(dmem_req), 0);
        chk("idle_ack_halt", 32'(halt), 0);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid = 1; ex_load = 1; ex_store = 0;
        ex_funct3 = 3'b010; ex_result = 32'h6; ex_rd_sel = 5'd8;
        @(posedge clk); #1;
        ex_valid = 0; ex_load = 0;
        chk("mis_flag", 32'(misalign), 1);
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_ready", 32'(ex_ready), 1);
        chk("mis_sel", 32'(wb_rd_sel), 0);
        @(posedge clk); #1;
        chk("mis_clr", 32'(misalign), 0);
`else
        mem(0, 3'b010, 32'h6, 0, 32'h0BAD_F00D, 5'd8, 0);
`endif

        // reset in the middle of an access
        ex_valid = 1; ex_load = 1; ex_store = 0;
        ex_funct3 = 3'b010; ex_result = 32'h300; ex_rd_sel = 5'd6;
        @(posedge clk); #1;
        ex_valid = 0; ex_load = 0;
        chk("rw_req", 32'(dmem_req), 1);
        #2 reset = 0;
        #1;
        chk("rw_req0", 32'(dmem_req), 0);
        chk("rw_halt", 32'(halt), 0);
        chk("rw_ready", 32'(ex_ready), 1);
        chk("rw_sel", 32'(wb_rd_sel), 0);
        @(posedge clk); #1;
        reset = 1;
        dmem_ack = 1; dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("rw_ack_sel", 32'(wb_rd_sel), 0);
        chk("rw_ack_req", 32'(dmem_req), 0);
        chk("rw_ack_ready", 32'(ex_ready), 1);

        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            a = a & 32'hFFFF_FFFC;
`endif
            if (kind == 0)
                alu($urandom, 5'($urandom));
            else
                mem(kind == 2, 3'($urandom), a, $urandom, $urandom,
                    5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports ex_valid (in, 1) and ex_ready (out, 1): the execute-stage handshake; a transfer occurs when both are high at a clk edge.
REQ-005 SHALL have port ex_result, in, WIDTH: the ALU result, or the effective address for a load or store.
REQ-006 SHALL have ports ex_store_data (in, WIDTH), ex_rd_sel (in, 5), ex_funct3 (in, 3), ex_load (in, 1) and ex_store (in, 1).
REQ-007 SHALL have ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, WIDTH), dmem_wdata (out, WIDTH) and dmem_wstrb (out, 4) to drive the data memory.
REQ-008 SHALL have ports dmem_ack (in, 1) and dmem_rdata (in, WIDTH) returned by the data memory.
REQ-009 SHALL have ports wb_rd_sel (out, 5) and wb_rd (out, WIDTH), which feed the write-back stage.
REQ-010 SHALL have port halt, out, 1: high while a memory access is outstanding.

Function
REQ-011 SHALL implement the FSM states IDLE and WAIT; ex_ready SHALL be 1 only in IDLE.
REQ-012 A transfer with ex_load=0 and ex_store=0 SHALL register wb_rd=ex_result and wb_rd_sel=ex_rd_sel, visible for exactly one cycle starting the next cycle (latency 1).
REQ-013 Any cycle without a completing result SHALL present wb_rd_sel=0, so the write-back stage performs no write.
REQ-014 A load or store transfer SHALL move the FSM to WAIT, and in the same cycle register dmem_req=1, dmem_we=ex_store and dmem_addr={ex_result[WIDTH-1:2],2'b00}.
REQ-015 In WAIT, the memory outputs SHALL hold stable and halt SHALL be 1 until the cycle dmem_ack=1 is sampled.
REQ-016 On that cycle, dmem_req SHALL drop to 0 and the FSM SHALL return to IDLE at the next edge.
REQ-017 A load SHALL present its formatted data on wb_rd together with its rd_sel for one cycle, starting the cycle after ack.
REQ-018 A store SHALL leave wb_rd_sel=0.
REQ-019 Load formatting SHALL select the byte lane from addr[1:0]: LB 000 and LH 001 sign-extend, LW 010 passes all 32 bits, LBU 100 and LHU 101 zero-extend.
REQ-020 Store strobes SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-021 Store data SHALL be replicated across the lanes (byte x4, half x2).
REQ-022 An undefined funct3 SHALL be treated as LW/SW.
REQ-023 A dmem_ack received in IDLE SHALL be ignored.
REQ-024 ex_rd_sel=0 SHALL yield wb_rd_sel=0 regardless of the operation.
REQ-025 A reset assertion during WAIT SHALL abandon the access immediately, with dmem_req=0 and no write-back.

Reset
REQ-026 While reset=0, the block SHALL hold: FSM=IDLE, ex_ready=1, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, wb_rd_sel=0, wb_rd=0, halt=0.
REQ-027 The block SHALL resume normal operation on the first clk edge after reset rises.

Configuration
REQ-028 With MEM_MISALIGN_TRAP_EN defined, a misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0) SHALL issue no dmem_req and SHALL stay in IDLE.
REQ-029 With MEM_MISALIGN_TRAP_EN defined, such an access SHALL pulse the extra output port misalign (out, 1) for one cycle and SHALL produce wb_rd_sel=0.
REQ-030 Without MEM_MISALIGN_TRAP_EN, the misalign port SHALL NOT exist and misaligned accesses SHALL proceed, using only the lane bits defined in REQ-019 and REQ-020.

Structure
REQ-031 The shared package mem_pkg SHALL hold the funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), the FSM state encoding and the strobe width constant 4.
REQ-032 Load lane extraction and sign extension SHALL live in one combinational sub-module, load_align.

Verification
REQ-033 ALU pass-through: ex_result=0x1234, rd_sel=5 -> next cycle wb_rd_sel=5, wb_rd=0x1234; the following cycle wb_rd_sel=0.
REQ-034 LB at addr 0x103 with rdata 0x80FF_FF7F and ack after 3 wait cycles -> dmem_addr=0x100; halt=1 for those cycles; wb_rd=0xFFFF_FF80.
REQ-035 SH at addr 0x202 with data 0x0000_ABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_rd_sel=0.
REQ-036 LHU at addr 0x2 with rdata 0xBEEF_0000 -> wb_rd=0x0000_BEEF; with the macro, LW at addr 0x6 -> misalign=1, dmem_req stays 0.
REQ-037 reset driven low in WAIT, then a spurious dmem_ack after release -> dmem_req=0 immediately, no write-back, ex_ready=1.
